// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares a single-port DataMemory between the CPU load/store path (port 0)
// and the debug/program-loader path (port 1). A request is captured in IDLE,
// arbitrated round-robin, and then driven onto the memory for exactly one
// ACCESS cycle. Read data comes back registered, together with a done pulse.
//
// Ports:
//   CLK, Reset                   clock; asynchronous active-low reset
//   reqN/rwN/addrN/wdataN        requester N inputs (rw: 1 = write)
//   gntN                         one-cycle pulse: request captured
//   doneN                        one-cycle pulse: access complete
//   rdataN                       read data, valid while doneN=1, held otherwise
//   RW/DAddr/Datain              memory controls, non-zero only during ACCESS
//   DataOut                      combinational read data from memory
//   busy                         high while not IDLE
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              RW,
  output logic [ADDR_W-1:0] DAddr,
  output logic [DATA_W-1:0] Datain,
  input  logic [DATA_W-1:0] DataOut,
  output logic              busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                last_q, last_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                win;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // On a tie the port that did not win last time is chosen.
    win      = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d   = win;
          rw_d    = win ? rw1 : rw0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          last_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (sel_q) begin
          done1_d  = 1'b1;
          rdata1_d = DataOut;
        end else begin
          done0_d  = 1'b1;
          rdata0_d = DataOut;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory controls decode straight from the state flop so that RW drops
  // as soon as reset is asserted, without waiting for a clock edge.
  assign busy   = (state_q == ACCESS);
  assign RW     = busy & rw_q;
  assign DAddr  = busy ? addr_q : '0;
  assign Datain = busy ? wdata_q : '0;

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule
